// File: rtl/apb_cmdq_pkg.sv
// Shared types for the APB command queue: command/response records and FSM states.
package apb_cmdq_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              write;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              write;
    } rsp_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

endpackage

// File: rtl/apb_cmdq_fifo.sv
// First-word-fall-through FIFO; head is visible on pop_data whenever not empty.
module apb_cmdq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     PCLK,
    input  logic                     PRESETn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [LVL_W-1:0] level_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_reg == LVL_W'(DEPTH));
    assign empty   = (level_reg == '0);
    assign level   = level_reg;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Empty reads return zero so downstream data outputs are clean after reset.
    assign pop_data = empty ? '0 : mem_reg[rd_ptr_reg];

    always_ff @(posedge PCLK) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            level_reg <= level_reg + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end

endmodule

// File: rtl/apb_cmd_queue.sv
// Queues APB commands, issues them one at a time to a master, and returns read data in order.
// Define APB_CMDQ_WRRESP_EN to also return a response for every completed write.
module apb_cmd_queue
    import apb_cmdq_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4
) (
    input  logic                       PCLK,
    input  logic                       PRESETn,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [ADDR_W-1:0]          cmd_addr,
    input  logic                       cmd_write,
    input  logic [DATA_W-1:0]          cmd_wdata,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_W-1:0]          rsp_data,
    output logic                       rsp_write,
    output logic                       m_start,
    output logic [ADDR_W-1:0]          m_addr,
    output logic                       m_write,
    output logic [DATA_W-1:0]          m_wdata,
    input  logic [DATA_W-1:0]          m_rdata,
    input  logic                       m_done,
    output logic                       busy,
    output logic [$clog2(CMD_DEPTH):0] cmd_level
);

    localparam int CLVL_W = $clog2(CMD_DEPTH) + 1;

    state_t state_reg, state_next;
    cmd_t   m_cmd_reg, m_cmd_next;
    logic   cmd_ready_reg, cmd_ready_next;

    cmd_t   cmd_in, cmd_head;
    logic   cmd_push, cmd_pop, cmd_full, cmd_empty;
    rsp_t   rsp_in, rsp_head;
    logic   rsp_push, rsp_pop, rsp_full, rsp_empty;
    logic   head_ok;

    logic [$clog2(RSP_DEPTH):0] rsp_level_unused;
    logic                       unused_bits;

    assign cmd_in   = '{addr: cmd_addr, write: cmd_write, wdata: cmd_wdata};
    assign cmd_push = cmd_valid && cmd_ready_reg;
    assign cmd_pop  = (state_reg == WAIT) && m_done;

    // Ready reflects the occupancy after this edge, so a full FIFO is never overrun.
    assign cmd_ready_next = cmd_pop ||
        !(cmd_full || (cmd_push && cmd_level == CLVL_W'(CMD_DEPTH - 1)));

`ifdef APB_CMDQ_WRRESP_EN
    assign head_ok   = !rsp_full;
    assign rsp_push  = cmd_pop;
    assign rsp_write = rsp_head.write;
`else
    assign head_ok   = cmd_head.write || !rsp_full;
    assign rsp_push  = cmd_pop && !m_cmd_reg.write;
    assign rsp_write = 1'b0;
`endif

    always_comb begin
        rsp_in = '0;
`ifdef APB_CMDQ_WRRESP_EN
        if (m_cmd_reg.write) begin
            rsp_in.write = 1'b1;
        end else begin
            rsp_in.data = m_rdata;
        end
`else
        rsp_in.data = m_rdata;
`endif
    end

    assign rsp_valid   = !rsp_empty;
    assign rsp_pop     = rsp_valid && rsp_ready;
    assign rsp_data    = rsp_head.data;
    assign unused_bits = ^{rsp_level_unused, rsp_head.write};

    assign cmd_ready = cmd_ready_reg;
    assign m_addr    = m_cmd_reg.addr;
    assign m_write   = m_cmd_reg.write;
    assign m_wdata   = m_cmd_reg.wdata;

    apb_cmdq_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .push      (cmd_push),
        .push_data (cmd_in),
        .pop       (cmd_pop),
        .pop_data  (cmd_head),
        .full      (cmd_full),
        .empty     (cmd_empty),
        .level     (cmd_level)
    );

    apb_cmdq_fifo #(.WIDTH($bits(rsp_t)), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .push      (rsp_push),
        .push_data (rsp_in),
        .pop       (rsp_pop),
        .pop_data  (rsp_head),
        .full      (rsp_full),
        .empty     (rsp_empty),
        .level     (rsp_level_unused)
    );

    // Head stays in the FIFO until completion; the master sees a registered copy.
    always_comb begin
        state_next = state_reg;
        m_cmd_next = m_cmd_reg;
        m_start    = 1'b0;
        busy       = 1'b1;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (!cmd_empty && head_ok) begin
                    state_next = ISSUE;
                    m_cmd_next = cmd_head;
                end
            end
            ISSUE: begin
                m_start    = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (m_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg     <= IDLE;
            m_cmd_reg     <= '0;
            cmd_ready_reg <= 1'b1;
        end else begin
            state_reg     <= state_next;
            m_cmd_reg     <= m_cmd_next;
            cmd_ready_reg <= cmd_ready_next;
        end
    end

endmodule

// File: doc/apb_cmd_queue.md
APB_CMD_QUEUE -- requirements
Module: apb_cmd_queue

Interface
REQ-001 The block SHALL have parameter CMD_DEPTH, default 4: command FIFO entries, power of two, minimum 2.
REQ-002 The block SHALL have parameter RSP_DEPTH, default 4: response FIFO entries, power of two, minimum 2.
REQ-003 The block SHALL have one clock, PCLK (input, 1); all logic is clocked on the rising edge.
REQ-004 The block SHALL have reset PRESETn (input, 1); it is asynchronous and active-low.
REQ-005 Command port SHALL be: cmd_valid in 1; cmd_ready out 1; cmd_addr in 32; cmd_write in 1; cmd_wdata in 32.
REQ-006 Response port SHALL be: rsp_valid out 1; rsp_ready in 1; rsp_data out 32 (read data, 0 for writes); rsp_write out 1 (kind of the response).
REQ-007 Master-side port SHALL be: m_start out 1; m_addr out 32; m_write out 1; m_wdata out 32; m_rdata in 32; m_done in 1 (one-cycle completion pulse).
REQ-008 Status outputs SHALL be: busy out 1 (a transaction is in flight); cmd_level out $clog2(CMD_DEPTH)+1 (command FIFO occupancy).

Function
REQ-009 A command SHALL be accepted on any rising edge where cmd_valid and cmd_ready are both 1.
REQ-010 cmd_ready SHALL equal the registered value of (command FIFO not full); it has no combinational path from cmd_valid or m_done.
REQ-011 The FSM SHALL use three states: IDLE, ISSUE and WAIT.
REQ-012 IDLE->ISSUE SHALL occur when the command FIFO is non-empty and the response FIFO is not full. A write with APB_CMDQ_WRRESP_EN undefined SHALL ignore the response FIFO condition.
REQ-013 In ISSUE, m_start SHALL be 1 for exactly one cycle, then the FSM SHALL go to WAIT.
REQ-014 In WAIT, the FSM SHALL go to IDLE on m_done; m_done outside WAIT SHALL be ignored.
REQ-015 m_addr, m_write and m_wdata SHALL be registered from the FIFO head on IDLE->ISSUE and held stable until m_done.
REQ-016 The command FIFO head SHALL be popped in the cycle m_done is sampled in WAIT.
REQ-017 Only one transaction SHALL be in flight at a time, so busy SHALL be 1 exactly in ISSUE and WAIT.
REQ-018 Minimum latency from cmd acceptance to m_start SHALL be 2 cycles (one cycle for the FIFO write, one for the IDLE decision).
REQ-019 On a read completion, {m_rdata, rsp_write=0} SHALL be pushed to the response FIFO in the m_done cycle. Space is guaranteed by REQ-012.
REQ-020 The response FIFO SHALL be first-word-fall-through and SHALL pop when rsp_valid and rsp_ready are both 1.
REQ-021 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave the level unchanged. FIFO pointers SHALL wrap modulo depth.
REQ-022 Commands and responses SHALL be delivered strictly in acceptance order.

Reset
REQ-023 Reset SHALL set: FSM to IDLE; both FIFOs empty; cmd_ready=1; rsp_valid=0; rsp_data=0; rsp_write=0; m_start=0; m_addr=0; m_write=0; m_wdata=0; busy=0; cmd_level=0.
REQ-024 Reset asserted mid-transaction SHALL discard all queued and in-flight commands without generating a response.

Configuration
REQ-025 Macro APB_CMDQ_WRRESP_EN SHALL control write responses.
REQ-026 With APB_CMDQ_WRRESP_EN defined, each write completion SHALL push {32'h0, rsp_write=1}, and writes SHALL also wait for response FIFO space.
REQ-027 With APB_CMDQ_WRRESP_EN undefined, writes SHALL produce no response, and rsp_write SHALL be constant 0.

Structure
REQ-028 Package apb_cmdq_pkg SHALL hold the command struct (addr, write, wdata), the response struct (data, write), the FSM state enum, and ADDR_W/DATA_W=32.
REQ-029 One sub-module, apb_cmdq_fifo (parameterised width/depth, FWFT, full/empty/level), SHALL be instantiated twice.

Verification
REQ-030 Write 0x1000_0000=0xDEADBEEF, then read the same address through apb_master/apb_slave -> one response, rsp_data=0xDEADBEEF, rsp_write=0.
REQ-031 Push 4 commands back-to-back with CMD_DEPTH=4 -> cmd_ready=0 after the 4th; all 4 execute in order; cmd_ready returns to 1 after the first m_done.
REQ-032 Issue 5 reads with rsp_ready=0 and RSP_DEPTH=4 -> exactly 4 reads complete; busy=0; the 5th m_start is withheld until one rsp pop.
REQ-033 Perform 2 writes with APB_CMDQ_WRRESP_EN defined -> 2 responses with rsp_write=1, data 0; with the macro undefined -> 0 responses.
REQ-034 Deassert PRESETn during WAIT -> all outputs go to their reset values immediately; a later write/read of 0x1000_0004=0xCAFEBABE completes correctly.
REQ-035 Hold cmd_valid continuously while rsp_ready toggles every cycle -> no lost or duplicated responses, and order matches commands.
